// File: rtl/cordic_angle_seq_rom.sv
// CORDIC elementary-angle table (atan 2^-i, optional atanh 2^-i via HYPERBOLIC_EN) with a per-iteration angle sequencer.
// Latency: random port 1 cycle; sequencer first beat 1 cycle after accepted start, then one beat per accepted cycle.
// Backpressure: seq_* held stable while seq_valid && !seq_ready; random port has none.
module cordic_angle_seq_rom #(
    parameter int ITERS  = 16,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              start,
    input  logic              seq_ready,
`ifdef HYPERBOLIC_EN
    input  logic              mode_hyp,
`endif
    output logic              seq_valid,
    output logic [4:0]        seq_idx,
    output logic [DATA_W-1:0] seq_angle,
    output logic              seq_last,
    output logic              busy
);

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic       dup;
    logic       rep_now;
    logic       last_now;
    logic       accept;
    logic       start_go;

`ifdef HYPERBOLIC_EN
    logic hyp_lat;
`endif

    function automatic logic [31:0] atan_q30(input logic [4:0] i);
        case (i)
            5'd0:    return 32'd843314857;
            5'd1:    return 32'd497837830;
            5'd2:    return 32'd263043837;
            5'd3:    return 32'd133525159;
            5'd4:    return 32'd67021688;
            5'd5:    return 32'd33543516;
            5'd6:    return 32'd16775851;
            5'd7:    return 32'd8388437;
            5'd8:    return 32'd4194283;
            5'd9:    return 32'd2097149;
            5'd10:   return 32'd1048576;
            default: return 32'h4000_0000 >> i;
        endcase
    endfunction

`ifdef HYPERBOLIC_EN
    // Entry 0 is unused by the hyperbolic iteration and reads as zero.
    function automatic logic [31:0] atanh_q30(input logic [4:0] i);
        case (i)
            5'd0:    return 32'd0;
            5'd1:    return 32'd589812981;
            5'd2:    return 32'd274247418;
            5'd3:    return 32'd134923406;
            5'd4:    return 32'd67196451;
            5'd5:    return 32'd33565361;
            5'd6:    return 32'd16778582;
            5'd7:    return 32'd8388779;
            5'd8:    return 32'd4194325;
            5'd9:    return 32'd2097155;
            5'd10:   return 32'd1048576;
            default: return 32'h4000_0000 >> i;
        endcase
    endfunction
`endif

    // Q2.30 constant rounded half-up to FRAC_W fraction bits; out-of-range index reads zero.
    function automatic logic [DATA_W-1:0] angle_at(input logic [4:0] i);
        logic [31:0] q;
        q = atan_q30(i);
`ifdef HYPERBOLIC_EN
        if (hyp_lat) q = atanh_q30(i);
`endif
        if (i > LAST) return '0;
        return DATA_W'((q + (32'd1 << (29 - FRAC_W))) >> (30 - FRAC_W));
    endfunction

    always_comb begin
        rep_now = 1'b0;
`ifdef HYPERBOLIC_EN
        rep_now = hyp_lat && (idx == 5'd4 || idx == 5'd13);
`endif
    end

    assign accept   = (state == STREAM) && seq_ready;
    assign last_now = (idx == LAST) && (!rep_now || dup);
    assign start_go = start && ((state == IDLE) || (accept && last_now));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (accept && last_now && !start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            dup <= 1'b0;
`ifdef HYPERBOLIC_EN
            hyp_lat <= 1'b0;
`endif
        end else if (start_go) begin
            dup <= 1'b0;
`ifdef HYPERBOLIC_EN
            hyp_lat <= mode_hyp;
            idx     <= mode_hyp ? 5'd1 : 5'd0;
`else
            idx     <= 5'd0;
`endif
        end else if (accept) begin
            // Repeated hyperbolic index: first acceptance only sets dup, index advances on the second.
            if (rep_now && !dup) begin
                dup <= 1'b1;
            end else begin
                dup <= 1'b0;
                idx <= idx + 5'd1;
            end
        end
    end

    always_comb begin
        seq_valid = (state == STREAM);
        busy      = (state == STREAM);
        seq_idx   = '0;
        seq_angle = '0;
        seq_last  = 1'b0;
        if (state == STREAM) begin
            seq_idx   = idx;
            seq_angle = angle_at(idx);
            seq_last  = last_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= angle_at(rd_addr);
        end
    end

endmodule
